// File: rtl/mem_cmd_arbiter.sv
// rtl/mem_cmd_arbiter.sv - round-robin DDR command arbiter with write-burst lock and in-order read return routing
module mem_cmd_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int STRB_W    = 16,
   parameter int TAG_DEPTH = 8
) (
   input  logic                        clk_sys,
   input  logic                        rst,
   input  logic                        init_done,
   input  logic [NUM_REQ-1:0]          req_cmd_valid,
   output logic [NUM_REQ-1:0]          req_cmd_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_cmd_addr,
   input  logic [NUM_REQ-1:0]          req_cmd_write,
   input  logic [NUM_REQ*8-1:0]        req_cmd_burst_len,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
   input  logic [NUM_REQ*STRB_W-1:0]   req_wr_strobe,
   input  logic [NUM_REQ-1:0]          req_wr_valid,
   output logic [NUM_REQ-1:0]          req_wr_ready,
   output logic [DATA_W-1:0]           req_rd_data,
   output logic [NUM_REQ-1:0]          req_rd_valid,
   input  logic [NUM_REQ-1:0]          req_rd_ready,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [ADDR_W-1:0]           cmd_addr,
   output logic                        cmd_write,
   output logic [7:0]                  cmd_burst_len,
   output logic [DATA_W-1:0]           wr_data,
   output logic [STRB_W-1:0]           wr_strobe,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   input  logic [DATA_W-1:0]           rd_data,
   input  logic                        rd_valid,
   output logic                        rd_ready,
   output logic [2:0]                  grant_id,
   output logic                        busy,
   output logic                        err_unexpected_rd
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;
   state_t state, state_next;

   logic [IDX_W-1:0]   gnt, rr_ptr, pick, idx;
   logic               pick_valid;
   logic [NUM_REQ-1:0] eligible;
   logic [7:0]         beat_cnt;

   logic [IDX_W-1:0]   tag_id  [TAG_DEPTH];
   logic [7:0]         tag_len [TAG_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     tag_count;
   logic [7:0]         rd_cnt;
   logic               tag_full, tag_empty, cmd_hs, wr_hs, rd_hs, push, pop;

   assign tag_full  = (tag_count == (PTR_W+1)'(TAG_DEPTH));
   assign tag_empty = (tag_count == '0);
   assign cmd_hs    = (state == CMD) && cmd_ready;
   assign wr_hs     = wr_valid && wr_ready;
   assign rd_hs     = rd_valid && rd_ready;
   assign push      = cmd_hs && !cmd_write;
   assign pop       = !tag_empty && rd_hs && (rd_cnt == tag_len[rd_ptr]);
   assign grant_id  = 3'(gnt);

   // Readers are masked while the tag FIFO is full so writers keep flowing.
   always_comb begin
      eligible   = req_cmd_valid & (req_cmd_write | {NUM_REQ{~tag_full}});
      pick_valid = 1'b0;
      pick       = '0;
      idx        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!pick_valid && eligible[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (init_done && pick_valid) state_next = CMD;
         CMD:     if (cmd_ready) state_next = cmd_write ? WDATA : IDLE;
         WDATA:   if (wr_hs && beat_cnt == 8'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_valid     = (state == CMD);
      req_cmd_ready = '0;
      req_wr_ready  = '0;
      wr_valid      = 1'b0;
      wr_data       = req_wr_data[gnt*DATA_W +: DATA_W];
      wr_strobe     = req_wr_strobe[gnt*STRB_W +: STRB_W];
      if (state == CMD) req_cmd_ready[gnt] = cmd_ready;
      if (state == WDATA) begin
         wr_valid          = req_wr_valid[gnt];
         req_wr_ready[gnt] = wr_ready;
      end
      // With no tag outstanding, stray read beats are drained and dropped.
      req_rd_data  = rd_data;
      req_rd_valid = '0;
      rd_ready     = rd_valid;
      if (!tag_empty) begin
         req_rd_valid[tag_id[rd_ptr]] = rd_valid;
         rd_ready                     = req_rd_ready[tag_id[rd_ptr]];
      end
      busy = (state != IDLE) || !tag_empty;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         gnt               <= '0;
         rr_ptr            <= '0;
         cmd_addr          <= '0;
         cmd_write         <= 1'b0;
         cmd_burst_len     <= 8'd0;
         beat_cnt          <= 8'd0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         tag_count         <= '0;
         rd_cnt            <= 8'd0;
         err_unexpected_rd <= 1'b0;
      end else begin
         if (state == IDLE && state_next == CMD) begin
            gnt           <= pick;
            cmd_addr      <= req_cmd_addr[pick*ADDR_W +: ADDR_W];
            cmd_write     <= req_cmd_write[pick];
            cmd_burst_len <= req_cmd_burst_len[pick*8 +: 8];
         end
         if (cmd_hs) begin
            rr_ptr   <= (gnt == IDX_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
            beat_cnt <= cmd_burst_len;
         end
         if (state == WDATA && wr_hs && beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= 8'd0;
         end else if (!tag_empty && rd_hs) begin
            rd_cnt <= rd_cnt + 8'd1;
         end
         case ({push, pop})
            2'b10:   tag_count <= tag_count + 1'b1;
            2'b01:   tag_count <= tag_count - 1'b1;
            default: tag_count <= tag_count;
         endcase
         if (tag_empty && rd_valid) err_unexpected_rd <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         tag_id[wr_ptr]  <= gnt;
         tag_len[wr_ptr] <= cmd_burst_len;
      end
   end
endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// tb/tb_mem_cmd_arbiter.sv - directed self-checking bench for mem_cmd_arbiter
module tb_mem_cmd_arbiter;
   localparam int NUM_REQ = 4, ADDR_W = 32, DATA_W = 128, STRB_W = 16, TAG_DEPTH = 8;

   logic                      clk_sys, rst, init_done;
   logic [NUM_REQ-1:0]        req_cmd_valid, req_cmd_ready, req_cmd_write;
   logic [NUM_REQ*ADDR_W-1:0] req_cmd_addr;
   logic [NUM_REQ*8-1:0]      req_cmd_burst_len;
   logic [NUM_REQ*DATA_W-1:0] req_wr_data;
   logic [NUM_REQ*STRB_W-1:0] req_wr_strobe;
   logic [NUM_REQ-1:0]        req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready;
   logic [DATA_W-1:0]         req_rd_data, wr_data, rd_data;
   logic                      cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, rd_ready;
   logic [ADDR_W-1:0]         cmd_addr;
   logic [7:0]                cmd_burst_len;
   logic [STRB_W-1:0]         wr_strobe;
   logic [2:0]                grant_id;
   logic                      busy, err_unexpected_rd;

   int n_checks = 0;
   int n_fail   = 0;

   mem_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .STRB_W(STRB_W), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk_sys(clk_sys), .rst(rst), .init_done(init_done),
      .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
      .req_cmd_addr(req_cmd_addr), .req_cmd_write(req_cmd_write),
      .req_cmd_burst_len(req_cmd_burst_len),
      .req_wr_data(req_wr_data), .req_wr_strobe(req_wr_strobe),
      .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
      .req_rd_data(req_rd_data), .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_burst_len(cmd_burst_len),
      .wr_data(wr_data), .wr_strobe(wr_strobe), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .grant_id(grant_id), .busy(busy), .err_unexpected_rd(err_unexpected_rd)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear_inputs();
      req_cmd_valid = '0; req_cmd_write = '0; req_cmd_addr = '0; req_cmd_burst_len = '0;
      req_wr_data = '0; req_wr_strobe = '0; req_wr_valid = '0; req_rd_ready = '0;
      cmd_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
   endtask

   task automatic do_reset(input logic init);
      clear_inputs();
      init_done = init;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_cmd(input logic [1:0] idx, input logic v, input logic w,
                          input logic [31:0] a, input logic [7:0] len);
      req_cmd_valid[idx] = v;
      req_cmd_write[idx] = w;
      req_cmd_addr[idx*ADDR_W +: ADDR_W] = a;
      req_cmd_burst_len[idx*8 +: 8] = len;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      #1;
      n_checks++; if ({cmd_valid, wr_valid, rd_ready, busy, err_unexpected_rd, cmd_write} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags got %b required 000000",
            {cmd_valid, wr_valid, rd_ready, busy, err_unexpected_rd, cmd_write}); end
      n_checks++; if ({req_cmd_ready, req_wr_ready, req_rd_valid} !== 12'h000) begin
         n_fail++; $display("FAIL reset_req_handshakes got %h required 000",
            {req_cmd_ready, req_wr_ready, req_rd_valid}); end
      n_checks++; if (grant_id !== 3'd0) begin
         n_fail++; $display("FAIL reset_grant_id got %0d required 0", grant_id); end
      n_checks++; if (cmd_addr !== 32'h0 || cmd_burst_len !== 8'h0) begin
         n_fail++; $display("FAIL reset_cmd_fields got addr %h len %h required 0 0", cmd_addr, cmd_burst_len); end
   endtask

   task automatic test_init_gate();
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) set_cmd(2'(i), 1'b1, 1'b0, 32'(32'h100 * (i + 1)), 8'd0);
      cmd_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++; if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL init_gate_no_cmd cycle %0d got %b required 0", c, cmd_valid); end
      end
      init_done = 1'b1;
      for (int g = 0; g < 4; g++) begin
         tick();
         #1;
         n_checks++; if (cmd_valid !== 1'b1 || grant_id !== 3'(g)) begin
            n_fail++; $display("FAIL init_rr_grant valid %b id %0d required 1 %0d", cmd_valid, grant_id, g); end
         n_checks++; if (cmd_addr !== 32'(32'h100 * (g + 1)) || req_cmd_ready !== 4'(1 << g)) begin
            n_fail++; $display("FAIL init_rr_fields addr %h ready %b required %h %b",
               cmd_addr, req_cmd_ready, 32'(32'h100 * (g + 1)), 4'(1 << g)); end
         tick();
         req_cmd_valid[g] = 1'b0;
         #1;
         n_checks++; if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL init_rr_gap got %b required 0", cmd_valid); end
      end
      n_checks++; if (busy !== 1'b1) begin
         n_fail++; $display("FAIL init_busy_tags got %b required 1", busy); end
   endtask

   task automatic test_write();
      logic [DATA_W-1:0] exp_d;
      logic [STRB_W-1:0] exp_s;
      do_reset(1'b1);
      cmd_ready = 1'b1;
      wr_ready  = 1'b1;
      set_cmd(2'd2, 1'b1, 1'b1, 32'h2000, 8'd3);
      req_wr_valid[2] = 1'b1;
      req_wr_data[1*DATA_W +: DATA_W] = {4{32'hBAD0_BAD1}};
      req_wr_strobe[1*STRB_W +: STRB_W] = 16'hFFFF;
      tick();
      #1;
      n_checks++; if (cmd_valid !== 1'b1 || grant_id !== 3'd2 || cmd_write !== 1'b1 || cmd_burst_len !== 8'd3) begin
         n_fail++; $display("FAIL wr_cmd got v%b id%0d w%b len%0d required v1 id2 w1 len3",
            cmd_valid, grant_id, cmd_write, cmd_burst_len); end
      n_checks++; if (wr_valid !== 1'b0) begin
         n_fail++; $display("FAIL wr_no_beat_in_cmd got %b required 0", wr_valid); end
      tick();
      req_cmd_valid[2] = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            req_wr_valid[2] = 1'b0;
            req_wr_valid[1] = 1'b1;
            #1;
            n_checks++; if (wr_valid !== 1'b0 || req_wr_ready !== 4'b0100) begin
               n_fail++; $display("FAIL wr_stall got valid %b ready %b required 0 0100", wr_valid, req_wr_ready); end
            tick();
         end
         exp_d = {4{32'hC0DE_0000 + 32'(b)}};
         exp_s = 16'(16'h000F << (4 * b));
         req_wr_data[2*DATA_W +: DATA_W] = exp_d;
         req_wr_strobe[2*STRB_W +: STRB_W] = exp_s;
         req_wr_valid[2] = 1'b1;
         req_wr_valid[1] = ((b % 2) == 1);
         #1;
         n_checks++; if (wr_valid !== 1'b1 || wr_data !== exp_d || wr_strobe !== exp_s) begin
            n_fail++; $display("FAIL wr_beat%0d got v%b d%h s%h required v1 d%h s%h",
               b, wr_valid, wr_data, wr_strobe, exp_d, exp_s); end
         n_checks++; if (req_wr_ready !== 4'b0100) begin
            n_fail++; $display("FAIL wr_ready_beat%0d got %b required 0100", b, req_wr_ready); end
         tick();
      end
      #1;
      n_checks++; if (wr_valid !== 1'b0 || req_wr_ready !== 4'b0000 || busy !== 1'b0) begin
         n_fail++; $display("FAIL wr_done got v%b r%b busy%b required 0 0000 0", wr_valid, req_wr_ready, busy); end
   endtask

   task automatic test_read_route();
      logic [NUM_REQ-1:0] exp_mask [3];
      logic [DATA_W-1:0]  exp_d;
      exp_mask[0] = 4'b0001; exp_mask[1] = 4'b0001; exp_mask[2] = 4'b1000;
      do_reset(1'b1);
      cmd_ready = 1'b1;
      req_rd_ready = 4'hF;
      set_cmd(2'd0, 1'b1, 1'b0, 32'h10, 8'd1);
      set_cmd(2'd3, 1'b1, 1'b0, 32'h30, 8'd0);
      tick();
      #1;
      n_checks++; if (grant_id !== 3'd0 || cmd_burst_len !== 8'd1) begin
         n_fail++; $display("FAIL rd_grant0 got id%0d len%0d required 0 1", grant_id, cmd_burst_len); end
      tick();
      req_cmd_valid[0] = 1'b0;
      tick();
      #1;
      n_checks++; if (grant_id !== 3'd3 || cmd_valid !== 1'b1) begin
         n_fail++; $display("FAIL rd_grant3 got id%0d v%b required 3 1", grant_id, cmd_valid); end
      tick();
      req_cmd_valid[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            req_rd_ready[3] = 1'b0;
            rd_valid = 1'b1;
            #1;
            n_checks++; if (rd_ready !== 1'b0 || req_rd_valid !== 4'b1000) begin
               n_fail++; $display("FAIL rd_backpressure got ready %b valid %b required 0 1000", rd_ready, req_rd_valid); end
            tick();
            req_rd_ready[3] = 1'b1;
         end
         exp_d = {4{32'hDA7A_0000 + 32'(k)}};
         rd_valid = 1'b1;
         rd_data = exp_d;
         #1;
         n_checks++; if (req_rd_valid !== exp_mask[k] || req_rd_data !== exp_d || rd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_beat%0d got valid %b ready %b data %h required %b 1 %h",
               k, req_rd_valid, rd_ready, req_rd_data, exp_mask[k], exp_d); end
         tick();
      end
      rd_valid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || err_unexpected_rd !== 1'b0) begin
         n_fail++; $display("FAIL rd_done got busy %b err %b required 0 0", busy, err_unexpected_rd); end
   endtask

   task automatic test_tag_full();
      int n_rd = 0;
      do_reset(1'b1);
      cmd_ready = 1'b1;
      wr_ready = 1'b1;
      req_rd_ready = 4'hF;
      set_cmd(2'd1, 1'b1, 1'b0, 32'h1000, 8'd0);
      for (int i = 0; i < 20; i++) begin
         #1;
         if (cmd_valid && req_cmd_ready[1]) n_rd++;
         tick();
      end
      #1;
      n_checks++; if (n_rd !== 8 || cmd_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL full_withheld got reads %0d v%b busy%b required 8 0 1", n_rd, cmd_valid, busy); end
      set_cmd(2'd0, 1'b1, 1'b1, 32'h4000, 8'd0);
      req_wr_valid[0] = 1'b1;
      tick();
      #1;
      n_checks++; if (cmd_valid !== 1'b1 || grant_id !== 3'd0 || cmd_write !== 1'b1) begin
         n_fail++; $display("FAIL full_write_grant got v%b id%0d w%b required 1 0 1", cmd_valid, grant_id, cmd_write); end
      tick();
      req_cmd_valid[0] = 1'b0;
      #1;
      n_checks++; if (wr_valid !== 1'b1 || req_wr_ready !== 4'b0001) begin
         n_fail++; $display("FAIL full_write_beat got v%b r%b required 1 0001", wr_valid, req_wr_ready); end
      tick();
      req_wr_valid[0] = 1'b0;
      tick();
      #1;
      n_checks++; if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL full_still_withheld got %b required 0", cmd_valid); end
      rd_valid = 1'b1;
      rd_data = {4{32'h0000_9999}};
      #1;
      n_checks++; if (req_rd_valid !== 4'b0010) begin
         n_fail++; $display("FAIL full_pop_route got %b required 0010", req_rd_valid); end
      tick();
      rd_valid = 1'b0;
      tick();
      #1;
      n_checks++; if (cmd_valid !== 1'b1 || grant_id !== 3'd1) begin
         n_fail++; $display("FAIL full_released got v%b id%0d required 1 1", cmd_valid, grant_id); end
   endtask

   task automatic test_unexpected_rd();
      do_reset(1'b1);
      rd_valid = 1'b1;
      #1;
      n_checks++; if (rd_ready !== 1'b1 || req_rd_valid !== 4'b0000 || err_unexpected_rd !== 1'b0) begin
         n_fail++; $display("FAIL unexp_drain got ready %b valid %b err %b required 1 0000 0",
            rd_ready, req_rd_valid, err_unexpected_rd); end
      tick();
      rd_valid = 1'b0;
      #1;
      n_checks++; if (err_unexpected_rd !== 1'b1 || rd_ready !== 1'b0) begin
         n_fail++; $display("FAIL unexp_set got err %b ready %b required 1 0", err_unexpected_rd, rd_ready); end
      tick();
      tick();
      n_checks++; if (err_unexpected_rd !== 1'b1) begin
         n_fail++; $display("FAIL unexp_sticky got %b required 1", err_unexpected_rd); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      cmd_ready = 1'b1;
      wr_ready = 1'b1;
      set_cmd(2'd2, 1'b1, 1'b1, 32'h5000, 8'd3);
      req_wr_valid[2] = 1'b1;
      tick();
      tick();
      req_cmd_valid[2] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if ({cmd_valid, wr_valid, rd_ready, busy, err_unexpected_rd, cmd_write} !== 6'b0) begin
         n_fail++; $display("FAIL midrst_flags got %b required 000000",
            {cmd_valid, wr_valid, rd_ready, busy, err_unexpected_rd, cmd_write}); end
      n_checks++; if (grant_id !== 3'd0 || req_wr_ready !== 4'b0 || cmd_addr !== 32'h0 || cmd_burst_len !== 8'h0) begin
         n_fail++; $display("FAIL midrst_fields got id%0d r%b addr %h len %h required 0 0000 0 0",
            grant_id, req_wr_ready, cmd_addr, cmd_burst_len); end
      req_wr_valid[2] = 1'b0;
      set_cmd(2'd1, 1'b1, 1'b0, 32'h6000, 8'd0);
      tick();
      #1;
      n_checks++; if (cmd_valid !== 1'b1 || grant_id !== 3'd1 || cmd_addr !== 32'h6000) begin
         n_fail++; $display("FAIL midrst_regrant got v%b id%0d addr %h required 1 1 6000", cmd_valid, grant_id, cmd_addr); end
   endtask

   initial begin
      rst = 1'b1;
      init_done = 1'b0;
      clear_inputs();
      test_reset();
      test_init_gate();
      test_write();
      test_read_route();
      test_tag_full();
      test_unexpected_rd();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_cmd_arbiter.md
# mem_cmd_arbiter

Round-robin arbiter that shares the DDR memory controller's command, write-data and read-data channels between NUM_REQ system-side requesters. It sits in the clk_sys domain directly in front of the controller. It serialises commands, locks the write-data channel to the granted writer for the whole burst, and routes returning read beats to the originating requester through an in-order tag FIFO. Grants are withheld until the controller reports init_done.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 32: command address width
- DATA_W, 128: data beat width
- STRB_W, 16: write strobe width (DATA_W/8)
- TAG_DEPTH, 8: outstanding read commands tracked (power of 2)

Ports (all synchronous to clk_sys):
- clk_sys  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init_done  in  1  controller ready; no grant while low
- req_cmd_valid / req_cmd_ready  in / out  NUM_REQ  per-requester command handshake
- req_cmd_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_cmd_write  in  NUM_REQ  1=write
- req_cmd_burst_len  in  NUM_REQ*8  beats minus one
- req_wr_data  in  NUM_REQ*DATA_W; req_wr_strobe  in  NUM_REQ*STRB_W
- req_wr_valid / req_wr_ready  in / out  NUM_REQ
- req_rd_data  out  DATA_W  broadcast to all requesters
- req_rd_valid / req_rd_ready  out / in  NUM_REQ
- cmd_valid / cmd_ready  out / in  1; cmd_addr  out  ADDR_W; cmd_write  out  1; cmd_burst_len  out  8
- wr_data  out  DATA_W; wr_strobe  out  STRB_W; wr_valid / wr_ready  out / in  1
- rd_data  in  DATA_W; rd_valid / rd_ready  in / out  1
- grant_id  out  3  index of current or last grant
- busy  out  1  state != IDLE or tag FIFO non-empty
- err_unexpected_rd  out  1  sticky; read beat arrived with tag FIFO empty

## Operation
- FSM states: IDLE, CMD, WDATA.
- IDLE: eligible = req_cmd_valid, with read requesters masked while the tag FIFO is full. If init_done and any requester is eligible, pick the first eligible index at or after rr_ptr (wrapping). Register grant_id, addr, write and burst_len. Go to CMD.
- CMD: cmd_valid=1 with registered fields. req_cmd_ready[grant_id]=cmd_ready; all other req_cmd_ready=0.
  - On handshake, rr_ptr <= grant_id+1 mod NUM_REQ.
  - A write loads beat_cnt=burst_len and goes to WDATA.
  - A read pushes {grant_id, burst_len} into the tag FIFO and goes to IDLE.
- WDATA: wr_valid=req_wr_valid[grant_id]; wr_data and wr_strobe muxed from grant_id; req_wr_ready[grant_id]=wr_ready, others 0.
  - Each beat handshake decrements beat_cnt.
  - The handshake with beat_cnt==0 returns the FSM to IDLE.
  - Write beats of other requesters are never forwarded.
- Read return is independent of the FSM and runs concurrently with it.
  - Head entry {id, rem}: req_rd_valid[id]=rd_valid, rd_ready=req_rd_ready[id], req_rd_data=rd_data.
  - Each beat handshake decrements rem. The beat with rem==0 pops the FIFO.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- FIFO empty and rd_valid=1: rd_ready=1 (drain), no req_rd_valid asserted, err_unexpected_rd set until reset.
- burst_len arithmetic is 8-bit unsigned; a burst is burst_len+1 beats (1..256).
- Reset mid-operation: FSM to IDLE, tag FIFO emptied, beat counters cleared. Any in-flight burst is abandoned and the requester reissues it.

## Timing
- Reset values: cmd_valid=0, wr_valid=0, rd_ready=0, all req_*_ready=0, all req_rd_valid=0, cmd_addr/cmd_write/cmd_burst_len=0, grant_id=0, rr_ptr=0, busy=0, err_unexpected_rd=0.
- Arbitration latency: request seen in IDLE at cycle N gives cmd_valid=1 at N+1. The minimum command-to-command spacing is 2 cycles for reads and 2+beats for writes.
- cmd fields are stable while cmd_valid=1 and cmd_ready=0.
- Grant is not revoked once in CMD, even if req_cmd_valid drops (protocol violation; not checked).
- Ready signals to requesters are combinational from the downstream ready. Data and valid muxes are combinational; no added latency on wr or rd beats.
- A tag pushed at cycle N is visible to the read router at N+1.
- A full tag FIFO blocks only read grants. Writes still arbitrate and skip any masked reader.

## Test plan
- Reset then init_done=0 with all 4 requesters issuing reads: no cmd_valid. Raise init_done: grants go 0,1,2,3 in order, each cmd_valid 1 cycle after IDLE.
- Requester 2 writes burst_len=3 while requester 1 toggles req_wr_valid: exactly 4 beats forwarded from requester 2, strobes intact. Requester 1 gets no wr_ready. FSM returns to IDLE after the 4th beat.
- Reads: requester 0 with len=1, then requester 3 with len=0. Controller returns 3 beats: beats 0–1 go to requester 0, beat 2 to requester 3. FIFO is empty afterwards and busy=0.
- 9 reads from requester 1 (TAG_DEPTH=8) with no return data: the 9th is withheld. A concurrent write from requester 0 is still granted. The first pop releases the 9th read.
- rd_valid=1 with FIFO empty: rd_ready=1, no req_rd_valid, err_unexpected_rd=1 and stays set.
- rst pulsed during the 2nd beat of a 4-beat write: next cycle all outputs are at reset values and grant_id=0. A new request from requester 1 is granted normally.
